// File: rtl/seq_divider_4_if.sv
// ---------------------------------------------------------------------------
// seq_divider_4_if
// Start/ready/done handshake bundle between the ALU control (master) and the
// multi-cycle divider (slave).
//
// Optional feature macro: DIV_ZERO_FLAG_EN adds the dbz flag to the bundle.
//
// Signals:
//   start      master -> slave  request, sampled only while ready=1
//   dividend   master -> slave  WIDTH-bit unsigned dividend
//   divisor    master -> slave  WIDTH-bit unsigned divisor
//   ready      slave -> master  idle, can accept start
//   done       slave -> master  one-cycle pulse when results become valid
//   quotient   slave -> master  WIDTH-bit quotient, held until next result
//   remainder  slave -> master  WIDTH-bit remainder, held until next result
//   dbz        slave -> master  divide-by-zero flag (DIV_ZERO_FLAG_EN only)
// ---------------------------------------------------------------------------
interface seq_divider_4_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
   logic             dbz;

   modport master (output start, dividend, divisor,
                   input  ready, done, quotient, remainder, dbz);
   modport slave  (input  start, dividend, divisor,
                   output ready, done, quotient, remainder, dbz);
`else
   modport master (output start, dividend, divisor,
                   input  ready, done, quotient, remainder);
   modport slave  (input  start, dividend, divisor,
                   output ready, done, quotient, remainder);
`endif
endinterface

// File: rtl/seq_divider_4.sv
// ---------------------------------------------------------------------------
// seq_divider_4
// Multi-cycle unsigned restoring divider. One quotient bit is produced per
// clock by a shift-and-trial-subtract step; a WIDTH-bit division takes
// WIDTH+1 edges from the accept edge to the done pulse.
//
// Optional feature macro: DIV_ZERO_FLAG_EN
//   defined   : divisor 0 finishes one edge after accept with quotient=all
//               ones, remainder=dividend and dbz=1.
//   undefined : divisor 0 runs the normal algorithm (same results, full
//               latency), no dbz flag.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_divider_4_if.slave (start/dividend/divisor in,
//          ready/done/quotient/remainder[/dbz] out, all outputs registered)
// ---------------------------------------------------------------------------
module seq_divider_4 #(
   parameter int WIDTH = 4   // legal range 2..16
) (
   input  logic           clk,
   input  logic           rst_n,
   seq_divider_4_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;       // iterations still to run
   logic [WIDTH-1:0] r_reg;     // partial remainder
   logic [WIDTH-1:0] q_reg;     // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] dvsr;      // divisor latched at accept
`ifdef DIV_ZERO_FLAG_EN
   logic             zero_op;   // current operation has divisor 0
`endif

   // One iteration step, evaluated from the current working registers.
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   // NOTE: every always_comb output gets a value on every path, so no latch
   // can be inferred.
   always_comb begin
      // The bit shifted out of r_reg stays as the extra MSB so a partial
      // remainder of up to 2*divisor-1 is compared correctly.
      r_shift = {r_reg, q_reg[WIDTH-1]};
      // Two's-complement subtraction; MSB set means R' < divisor (borrow).
      trial   = r_shift + ~{1'b0, dvsr} + (WIDTH + 1)'(1);
      borrow  = trial[WIDTH];
      r_next  = borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      q_next  = {q_reg[WIDTH-2:0], ~borrow};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side reads the pre-edge value of the registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the working registers are reset along with the outputs;
         // they are plain flops, not a memory, so this costs nothing extra.
         state         <= IDLE;
         cnt           <= '0;
         r_reg         <= '0;
         q_reg         <= '0;
         dvsr          <= '0;
         bus.ready     <= 1'b1;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
         zero_op       <= 1'b0;
         bus.dbz       <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;   // pulse: only the final edge raises it
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  dvsr      <= bus.divisor;
                  r_reg     <= '0;
                  q_reg     <= bus.dividend;
                  state     <= RUN;
                  bus.ready <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                  bus.dbz   <= 1'b0;
                  zero_op   <= (bus.divisor == '0);
                  // Divide by zero needs no iterations, only the result edge.
                  cnt       <= (bus.divisor == '0) ? CW'(1) : CW'(WIDTH);
`else
                  cnt       <= CW'(WIDTH);
`endif
               end
            end

            RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state         <= IDLE;
                  bus.ready     <= 1'b1;
                  bus.done      <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                  if (zero_op) begin
                     // q_reg still holds the untouched dividend here.
                     bus.quotient  <= '1;
                     bus.remainder <= q_reg;
                     bus.dbz       <= 1'b1;
                  end else begin
                     bus.quotient  <= q_next;
                     bus.remainder <= r_next;
                  end
`else
                  bus.quotient  <= q_next;
                  bus.remainder <= r_next;
`endif
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
